// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction-memory loader.
// Takes a valid/ready stream of machine-code words and writes them to the
// instruction RAM from address 0 upward. Every location above the program is
// then padded with FILL_WORD, and cpu_run is raised to release the CPU.
// Optional build macro IMEM_LOADER_CHECKSUM_EN adds a running sum of the
// accepted stream words on the checksum output.
module imem_loader #(
  parameter int                DEPTH     = 512,
  parameter int                ADDR_W    = 9,
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] FILL_WORD = 32'hFFFF_FFFF
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              busy,
  output logic              done,
  output logic              cpu_run,
  output logic              overflow_err,
`ifdef IMEM_LOADER_CHECKSUM_EN
  output logic [DATA_W-1:0] checksum,
`endif
  output logic [ADDR_W:0]   word_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_FILL,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] ptr_q;
  logic              hs;
  logic              start_ok;
  logic              at_last;

  // Status outputs decode straight from the state register.
  assign in_ready = (state_q == S_LOAD);
  assign busy     = (state_q == S_LOAD) || (state_q == S_FILL);
  assign cpu_run  = (state_q == S_DONE);

  // A stream word is taken only while loading; start is honoured only at rest.
  assign hs       = in_valid & in_ready;
  assign start_ok = start & ((state_q == S_IDLE) || (state_q == S_DONE));
  assign at_last  = (ptr_q == LAST_ADDR);

  // State register.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block ordering.
    if (!RST_N) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode: the top address ends the load directly, in_last below it
  // diverts to padding, and padding ends once the top address has been issued.
  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start) state_d = S_LOAD;
      S_LOAD: begin
        if (hs) begin
          if (at_last)      state_d = S_DONE;
          else if (in_last) state_d = S_FILL;
        end
      end
      S_FILL: if (at_last) state_d = S_DONE;
      S_DONE: if (start) state_d = S_LOAD;
      default: state_d = S_IDLE;
    endcase
  end

  // Write port, pointer, counters and status flags; all writes are registered,
  // so a write appears on the RAM port one cycle after it is decided.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      ptr_q        <= '0;
      ram_we       <= 1'b0;
      ram_addr     <= '0;
      ram_wdata    <= '0;
      word_count   <= '0;
      overflow_err <= 1'b0;
      done         <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      checksum     <= '0;
`endif
    end else begin
      ram_we <= 1'b0;
      done   <= (state_d == S_DONE) && (state_q != S_DONE);

      if (start_ok) begin
        ptr_q        <= '0;
        word_count   <= '0;
        overflow_err <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        checksum     <= '0;
`endif
      end

      if (hs) begin
        ram_we     <= 1'b1;
        ram_addr   <= ptr_q;
        ram_wdata  <= in_data;
        word_count <= word_count + 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        checksum   <= checksum + in_data;
`endif
        // The pointer parks at the top address instead of wrapping.
        if (!at_last)     ptr_q        <= ptr_q + 1'b1;
        else if (!in_last) overflow_err <= 1'b1;
      end

      if (state_q == S_FILL) begin
        ram_we    <= 1'b1;
        ram_addr  <= ptr_q;
        ram_wdata <= FILL_WORD;
        if (!at_last) ptr_q <= ptr_q + 1'b1;
      end
    end
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time instruction-memory loader placed directly upstream of the CPU's instruction RAM.
- Accepts a valid/ready stream of 32-bit machine-code words and writes them to consecutive RAM addresses starting at 0.
- Pads every remaining location with the end-instruction word, then asserts cpu_run to release the CPU.
- Replaces the file-based preload with synthesizable hardware.

Parameters:
DEPTH, 512, instruction RAM depth in words
ADDR_W, 9, RAM address width; DEPTH == 2**ADDR_W
DATA_W, 32, instruction word width
FILL_WORD, 32'hFFFF_FFFF, pad value written above the loaded program (CPU end instruction)

Ports:
CLK  in  1  clock; all logic on rising edge
RST_N  in  1  synchronous active-low reset
start  in  1  one-cycle pulse; begins a load; honoured only in IDLE or DONE
in_valid  in  1  stream word valid
in_data  in  DATA_W  stream word
in_last  in  1  marks final program word; qualified by in_valid
in_ready  out  1  loader can accept a word
ram_we  out  1  instruction RAM write enable
ram_addr  out  ADDR_W  RAM write address
ram_wdata  out  DATA_W  RAM write data
busy  out  1  high in LOAD or FILL
done  out  1  one-cycle pulse on entry to DONE
cpu_run  out  1  level; CPU may fetch; high only in DONE
overflow_err  out  1  sticky; the word at address DEPTH-1 was accepted without in_last
word_count  out  ADDR_W+1  number of stream words accepted in the current or last load

Behaviour:
- Reset (RST_N=0 at a clock edge):
  - State goes to IDLE.
  - All outputs go to 0: ram_addr=0, ram_wdata=0, word_count=0, overflow_err=0, cpu_run=0.
  - Reset mid-LOAD or mid-FILL abandons the load; no further RAM writes occur.
- FSM states: IDLE, LOAD, FILL, DONE.
- IDLE:
  - in_ready=0.
  - start → LOAD; clears the write pointer, word_count and overflow_err.
- LOAD:
  - in_ready=1.
  - Handshake = in_valid & in_ready.
  - Each handshake registers ram_we=1, ram_addr=ptr, ram_wdata=in_data; these appear the cycle after acceptance (1-cycle write latency).
  - Each handshake also increments ptr and word_count.
  - Handshake with in_last at ptr<DEPTH-1 → FILL.
  - Handshake at ptr==DEPTH-1 → DONE, no FILL; if in_last=0, set overflow_err.
  - in_ready drops in the cycle after the transition.
  - No handshake → ram_we=0 next cycle.
- FILL:
  - in_ready=0.
  - One write per cycle: ram_we=1, ram_wdata=FILL_WORD, addresses ptr..DEPTH-1 ascending.
  - After the write to DEPTH-1 is issued → DONE.
  - Pad writes take DEPTH-word_count cycles.
- DONE:
  - done pulses for exactly 1 cycle on entry; cpu_run=1 from that same cycle.
  - ram_we=0.
  - start → LOAD: cpu_run drops on the following cycle, and overflow_err and word_count clear.
- start while busy: ignored.
- start in the same cycle as in_valid in IDLE: no word accepted (in_ready=0 that cycle).
- ptr is ADDR_W bits and never wraps; the LOAD→DONE rule at DEPTH-1 prevents wrap-around.
- in_data/in_last are ignored whenever in_valid=0.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- When defined:
  - Adds output checksum [DATA_W-1:0], the modulo-2^DATA_W sum of all accepted stream words (pad words excluded).
  - Cleared by reset and by an honoured start; updated the cycle after each handshake.
  - Stable while in DONE.
- When undefined: the port and adder are absent; all other behaviour is identical.

Test Plan:
- Reset then 3-word load (DEPTH=512):
  - Stimulus: start; words 0x20080005, 0x20090003, 0x01095020 with in_last on the third.
  - Required: RAM[0..2] hold those words; RAM[3..511]=0xFFFFFFFF; word_count=3; overflow_err=0.
  - Timing: done pulses 509 cycles after the last write; cpu_run=1.
- Backpressure gaps: in_valid toggled 1,0,0,1 over 2 words (last on the second) → exactly two writes at addresses 0 and 1, each 1 cycle after its handshake; no write in the gap cycles.
- Full program, no last: 512 words with in_last never set → no FILL; DONE entered right after the 512th write; overflow_err=1; word_count=512.
- Reset mid-FILL: RST_N=0 while ram_addr=100 → next cycle ram_we=0, busy=0, cpu_run=0, word_count=0; stays IDLE until start.
- Reload from DONE plus ignored start: start in DONE → cpu_run=0 next cycle; start pulsed during LOAD is ignored (ptr is not reset).
- Checksum (macro defined): words 0xFFFFFFFF and 0x00000002 → checksum=0x00000001 in DONE.
